// File: rtl/ps2_event_rx_pkg.sv
// rtl/ps2_event_rx_pkg.sv - shared constants, state encoding and event layout for the PS/2 event receiver
package ps2_event_rx_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_OVR0    = 8'h00;
  localparam logic [7:0] PS2_OVR1    = 8'hFF;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  // A frame is good when the stop bit is high and data plus parity has odd weight.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity, input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous show-ahead event FIFO with sticky overflow on dropped pushes
module ps2_event_fifo
  import ps2_event_rx_pkg::*;
#(
  parameter int WIDTH = EV_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full && !do_pop) overflow <= 1'b1;
      else if (clear_err)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_event_rx.sv
// rtl/ps2_event_rx.sv - PS/2 keyboard receiver: sync, clock filter, frame FSM, prefix folding into a buffered event stream
module ps2_event_rx
  import ps2_event_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                            sys_clk,
  input  logic                            reset,
  input  logic                            PS2Clk,
  input  logic                            PS2Data,
  input  logic                            rd_en,
  input  logic                            clear_err,
  output logic                            ev_valid,
  output logic [7:0]                      ev_code,
  output logic                            ev_break,
  output logic                            ev_ext,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
  output logic                            overflow,
  output logic                            frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2Data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered level follows the synced clock only after FILTER_LEN identical samples.
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;
  logic          flt_done;
  logic          fall;

  assign flt_done = (clk_s2 != filt_clk) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = flt_done && !clk_s2;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 == filt_clk) begin
      flt_cnt <= '0;
    end else if (flt_done) begin
      filt_clk <= clk_s2;
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end

  ps2_state_t    state, state_next;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          shift_en, par_en, frame_done, abort;
  logic          good;

  assign timeout = (state != ST_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign good    = frame_ok(shreg, par_bit, dat_s2);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    if (timeout) begin
      state_next = ST_IDLE;
      abort      = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: if (!dat_s2) state_next = ST_DATA;
        ST_DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          par_en     = 1'b1;
          state_next = ST_STOP;
        end
        ST_STOP: begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (state == ST_IDLE) bitcnt <= '0;
      else if (shift_en)    bitcnt <= bitcnt + 3'd1;
      if (shift_en) shreg   <= {dat_s2, shreg[7:1]};
      if (par_en)   par_bit <= dat_s2;
      if (state == ST_IDLE || fall) tcnt <= '0;
      else                          tcnt <= tcnt + TW'(1);
    end
  end

  logic       ext_flag, brk_flag;
  logic       push_valid;
  ps2_event_t push_ev;

  // Accepted bytes are folded here; the event reaches the FIFO one cycle after the stop edge.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      push_valid <= 1'b0;
      push_ev    <= '0;
      frame_err  <= 1'b0;
    end else begin
      push_valid <= 1'b0;
      frame_err  <= abort || (frame_done && !good);
      if (abort || (frame_done && !good)) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (frame_done) begin
        if (shreg == PS2_PFX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PS2_PFX_BRK) begin
          brk_flag <= 1'b1;
        end else if (shreg == PS2_OVR0 || shreg == PS2_OVR1) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          push_valid <= 1'b1;
          push_ev    <= '{brk: brk_flag, ext: ext_flag, code: shreg};
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
        end
      end
    end
  end

  logic [EV_W-1:0] head_raw;
  ps2_event_t      head;
  logic            fifo_empty;

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (reset),
    .wr_en     (push_valid),
    .wr_data   (push_ev),
    .rd_en     (rd_en),
    .clear_err (clear_err),
    .rd_data   (head_raw),
    .empty     (fifo_empty),
    .count     (ev_count),
    .overflow  (overflow)
  );

  assign head     = ps2_event_t'(head_raw);
  assign ev_valid = !fifo_empty;
  assign ev_code  = head.code;
  assign ev_break = head.brk;
  assign ev_ext   = head.ext;

endmodule
